// File: rtl/asrv32_fetch_pkg.sv
// rtl/asrv32_fetch_pkg.sv - shared constants and types for the ASRV32 fetch stage
package asrv32_fetch_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int          FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/asrv32_fetch_fifo.sv
// rtl/asrv32_fetch_fifo.sv - 2-entry {pc, inst} FIFO with push, pop and priority clear
module asrv32_fetch_fifo
  import asrv32_fetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_data,
  output logic [1:0]   o_count,
  output logic [1:0]   o_count_nxt
);

  fetch_entry_t mem0_q, mem0_d, mem1_q, mem1_d;
  logic         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // next-state: clear wins, otherwise push (also when full if popping) and pop
  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    if (i_clear) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      do_push = i_push && ((count_q != 2'(FIFO_DEPTH)) || i_pop);
      do_pop  = i_pop && (count_q != 2'd0);
      if (do_push) begin
        if (wr_ptr_q) mem1_d = i_data;
        else          mem0_d = i_data;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_data      = rd_ptr_q ? mem1_q : mem0_q;
  assign o_count     = count_q;
  assign o_count_nxt = count_d;

endmodule

// File: rtl/asrv32_fetch.sv
// rtl/asrv32_fetch.sv - ASRV32 fetch stage; ASRV32_FETCH_ALIGN_CHECK_EN adds misaligned-redirect detection
module asrv32_fetch
  import asrv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc
`ifdef ASRV32_FETCH_ALIGN_CHECK_EN
  ,
  output logic        o_misaligned
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;          // address of the outstanding/next request
  logic [31:0]  redir_q, redir_d;    // redirect target parked while a drop is pending
  logic [31:0]  last_pc_q, last_pc_d;
  logic         hold_q, hold_d;      // fetch parked on a misaligned target
  logic         flush_bad;
  logic [31:0]  target;
  logic         push, pop, can_issue;
  fetch_entry_t head;
  logic [1:0]   count, count_nxt;

`ifdef ASRV32_FETCH_ALIGN_CHECK_EN
  logic misal_q;
  assign flush_bad = i_flush && (i_flush_pc[1:0] != 2'b00);
  assign target    = i_flush_pc;
  assign o_misaligned = misal_q;
  // one-cycle pulse on a misaligned redirect
  always_ff @(posedge i_clk) begin
    if (i_rst) misal_q <= 1'b0;
    else       misal_q <= flush_bad;
  end
`else
  assign flush_bad = 1'b0;
  assign target    = i_flush_pc & ~32'h3;
`endif

  assign o_valid     = (count != 2'd0);
  assign o_inst      = o_valid ? head.inst : NOP_INST;
  assign o_pc        = o_valid ? head.pc : last_pc_q;
  assign o_imem_req  = (state_q != ST_IDLE);
  assign o_imem_addr = pc_q;

  assign pop  = o_valid && i_ready;
  assign push = (state_q == ST_REQ) && i_imem_ack && !i_flush;

  asrv32_fetch_fifo u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (push),
    .i_pop      (pop),
    .i_clear    (i_flush),
    .i_data     ({pc_q, i_imem_data}),
    .o_data     (head),
    .o_count    (count),
    .o_count_nxt(count_nxt)
  );

  // next-state: request sequencing, redirect handling and drop of stale data
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    redir_d   = redir_q;
    hold_d    = i_flush ? flush_bad : hold_q;
    last_pc_d = o_valid ? head.pc : last_pc_q;
    can_issue = (count_nxt < 2'(FIFO_DEPTH)) && !hold_d;
    case (state_q)
      ST_IDLE: begin
        if (i_flush) pc_d = target;
        state_d = can_issue ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        if (i_imem_ack) begin
          pc_d    = i_flush ? target : pc_q + 32'd4;
          state_d = can_issue ? ST_REQ : ST_IDLE;
        end else if (i_flush) begin
          redir_d = target;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (i_imem_ack) begin
          pc_d    = i_flush ? target : redir_q;
          state_d = can_issue ? ST_REQ : ST_IDLE;
        end else if (i_flush) begin
          redir_d = target;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and PC registers; reset beats flush and ack
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      redir_q   <= RESET_PC;
      last_pc_q <= RESET_PC;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      redir_q   <= redir_d;
      last_pc_q <= last_pc_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: doc/asrv32_fetch.md
# asrv32_fetch

Instruction fetch stage for the ASRV32 core: owns the program counter and issues word requests to instruction memory. Buffers returned instructions with their PCs in a 2-entry FIFO. Presents them to the decoder with a valid/ready handshake. Handles redirect (branch/jump/trap) flushes, including discarding a memory response already in flight.

## Interface

- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `o_imem_addr` out 32: word address of the current request.
- `o_imem_req` out 1: request valid.
- `i_imem_ack` in 1: memory accepted the request and returned data (same cycle).
- `i_imem_data` in 32: instruction word, valid when `i_imem_ack`.
- `o_inst` out 32: instruction at FIFO head, to the decoder's `i_inst`.
- `o_pc` out 32: PC of `o_inst`.
- `o_valid` out 1: `o_inst`/`o_pc` valid.
- `i_ready` in 1: decoder accepts the head this cycle.
- `i_flush` in 1: redirect request.
- `i_flush_pc` in 32: redirect target.
- `o_misaligned` out 1: misaligned redirect pulse. Present only with `ASRV32_FETCH_ALIGN_CHECK_EN`.

## Operation

- Memory protocol: at most one outstanding request.
  - `o_imem_addr` is held stable while `o_imem_req=1` until `i_imem_ack`.
  - `i_imem_ack` is legal in the request cycle or any later cycle.
- Issue rule: a new request is raised the cycle after an ack, or when idle, iff `fifo_count + outstanding < 2` after this edge's updates.
  - `fetch_pc` advances by 4 on each ack.
- Ack with no drop pending: `{fetch_pc, i_imem_data}` is pushed into the FIFO.
- Decoder handshake:
  - Transfer occurs when `o_valid & i_ready`; the head is popped on that edge.
  - `o_valid = (fifo_count != 0)`.
  - When empty, `o_inst = 32'h0000_0013` (NOP) and `o_pc` holds the last value.
- FSM states: `IDLE` (no request), `REQ` (request outstanding), `DROP` (outstanding request whose data must be discarded).
  - `IDLE -> REQ`: issue rule satisfied.
  - `REQ -> IDLE`: ack and the issue rule fails; `REQ -> REQ`: ack and the issue rule holds.
  - `REQ -> DROP`: `i_flush` without ack.
  - `DROP -> IDLE/REQ`: on ack; data discarded, next request goes to the redirected PC.
- Flush:
  - FIFO is cleared and `fetch_pc <= i_flush_pc`.
  - If flush and ack coincide, the acked data is discarded and there is no `DROP`.
  - Flush beats same-cycle push and pop; a same-cycle pop is still counted as consumed by the decoder.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Reset beats flush and ack. An ack arriving in the cycle after reset with no request is ignored.

## Timing

- Reset values:
  - `o_imem_req=0`, `o_imem_addr=RESET_PC`.
  - `o_valid=0`, `o_inst=32'h0000_0013`, `o_pc=RESET_PC`.
  - `o_misaligned=0`, FSM=`IDLE`.
- First cycle after reset release: `o_imem_req=1`, `o_imem_addr=RESET_PC`.
- Ack to `o_valid`: 1 cycle (data registered into the FIFO).
- Zero-wait memory with `i_ready=1`: one instruction per cycle sustained.
- Flush to new request: the next cycle (no drop pending), or the cycle after the drop's ack.
- `o_valid` is 0 in the cycle after a flush.

## Configuration

- `ASRV32_FETCH_ALIGN_CHECK_EN` defined:
  - A flush with `i_flush_pc[1:0] != 0` loads the PC and pulses `o_misaligned` for 1 cycle.
  - Fetch then holds in `IDLE` (no requests) until the next flush with an aligned target.
- Undefined: `i_flush_pc[1:0]` is ignored (treated as 0) and the `o_misaligned` port is absent.

## Structure

- Add to `asrv32_header.vh`:
  - the NOP encoding constant `32'h0000_0013`;
  - the FIFO depth constant (2);
  - the FSM state encodings.
- Sub-module `asrv32_fetch_fifo`: 2-entry, 64-bit-wide (`{pc, inst}`) synchronous FIFO with push, pop and clear.
  - Count output; same-cycle push and pop when full.
  - Clear has priority.

## Test plan

- Reset release, memory acks every cycle, `i_ready=1`: requests 0x0, 0x4, 0x8 on consecutive cycles; `o_valid` from cycle 2 with `o_pc` 0x0, 0x4, 0x8 and matching `o_inst`.
- `i_ready=0` for 5 cycles: at most 2 instructions buffered, `o_imem_req` drops, nothing lost or duplicated after `i_ready=1`.
- Memory ack delayed 3 cycles: `o_imem_addr` stable throughout; one instruction per 4 cycles.
- Flush to 0x100 while a request to 0x8 is unacked: `DROP` entered; 0x8 data never appears; next request is 0x100; first `o_pc` is 0x100.
- Flush to 0x200 coincident with ack and pop: acked data discarded, FIFO empty next cycle, request 0x200 next cycle.
- With `ASRV32_FETCH_ALIGN_CHECK_EN`, flush to 0x102: `o_misaligned` high 1 cycle, no requests until a flush to 0x104.
